// File: rtl/nn_pkg.sv
// Shared types and constants for the MNIST inference datapath blocks.
package nn_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StIssue,
    StDrain,
    StWb,
    StDone
  } nn_state_e;

  localparam logic [2:0] LAYER_1 = 3'b001;
  localparam logic [2:0] LAYER_2 = 3'b010;
  localparam logic [2:0] LAYER_3 = 3'b100;

  localparam int unsigned N_IN_DEF = 784;
  localparam int unsigned N_H1_DEF = 20;
  localparam int unsigned N_H2_DEF = 20;

endpackage

// File: rtl/nn_valid_pipe.sv
// Fixed-latency valid/layer-tag delay line; emits the one-hot accumulate enable.
module nn_valid_pipe #(
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid,
  input  logic [2:0] tag,
  output logic [2:0] acc_en
);

  logic [PIPE_LAT-1:0]      vld_q;
  logic [PIPE_LAT-1:0][2:0] tag_q;

  // Never stalls: bubbles travel down the line like any other entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q[0] <= valid;
      tag_q[0] <= valid ? tag : 3'b000;
      for (int i = 1; i < PIPE_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign acc_en = tag_q[PIPE_LAT-1] & {3{vld_q[PIPE_LAT-1]}};

endmodule

// File: rtl/nn_layer_sequencer.sv
// Layer-by-layer issue sequencer for the 784-20-20-10 network.
// Optional cycle counter output enabled by defining NN_CYCLE_COUNT_EN.
module nn_layer_sequencer
  import nn_pkg::*;
#(
  parameter int unsigned N_IN     = N_IN_DEF,
  parameter int unsigned N_H1     = N_H1_DEF,
  parameter int unsigned N_H2     = N_H2_DEF,
  parameter int unsigned PIPE_LAT = 2,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Compute,
  input  logic              Hold,
  output logic              Busy,
  output logic              Done,
  output logic [2:0]        Layer,
  output logic [ADDR_W-1:0] Rd_addr,
  output logic              Bias_sel,
  output logic              Acc_clr,
  output logic [2:0]        Acc_en,
`ifdef NN_CYCLE_COUNT_EN
  output logic [15:0]       Cycles,
`endif
  output logic              Wb
);

  localparam int unsigned DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  nn_state_e         state_q;
  logic [2:0]        layer_q;
  logic [ADDR_W-1:0] idx_q;
  logic [DRAIN_W-1:0] drain_q;
  logic              acc_clr_q, wb_q, busy_q, done_q;
  logic [ADDR_W-1:0] fan_in;
  logic              is_last, issue_valid;

  always_comb begin
    fan_in = ADDR_W'(N_H2);
    if (layer_q[0]) fan_in = ADDR_W'(N_IN);
    else if (layer_q[1]) fan_in = ADDR_W'(N_H1);
  end

  assign is_last     = (idx_q == fan_in);
  assign issue_valid = (state_q == StIssue) && !Hold;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= StIdle;
      layer_q   <= '0;
      idx_q     <= '0;
      drain_q   <= '0;
      acc_clr_q <= 1'b0;
      wb_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      acc_clr_q <= 1'b0;
      wb_q      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (Compute) begin
            state_q   <= StClear;
            layer_q   <= LAYER_1;
            idx_q     <= '0;
            acc_clr_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        StClear: begin
          state_q <= StIssue;
          idx_q   <= '0;
        end
        StIssue: begin
          if (!Hold) begin
            if (is_last) begin
              state_q <= StDrain;
              drain_q <= '0;
            end else begin
              idx_q <= idx_q + ADDR_W'(1);
            end
          end
        end
        StDrain: begin
          // Last accumulate lands in the final drain cycle.
          if (drain_q == DRAIN_W'(PIPE_LAT - 1)) begin
            state_q <= StWb;
            wb_q    <= 1'b1;
          end else begin
            drain_q <= drain_q + DRAIN_W'(1);
          end
        end
        StWb: begin
          idx_q <= '0;
          if (layer_q == LAYER_3) begin
            state_q <= StDone;
            layer_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q   <= StClear;
            layer_q   <= {layer_q[1:0], 1'b0};
            acc_clr_q <= 1'b1;
          end
        end
        StDone: begin
          if (!Compute) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  nn_valid_pipe #(
    .PIPE_LAT(PIPE_LAT)
  ) u_valid_pipe (
    .clk   (Clk),
    .rst_n (Reset_n),
    .valid (issue_valid),
    .tag   (layer_q),
    .acc_en(Acc_en)
  );

`ifdef NN_CYCLE_COUNT_EN
  logic [15:0] cycles_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cycles_q <= '0;
    end else if ((state_q == StIdle) && Compute) begin
      cycles_q <= '0;
    end else if (busy_q && (cycles_q != 16'hFFFF)) begin
      cycles_q <= cycles_q + 16'd1;
    end
  end

  assign Cycles = cycles_q;
`endif

  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Layer    = layer_q;
  assign Rd_addr  = idx_q;
  assign Bias_sel = (state_q == StIssue) && is_last;
  assign Acc_clr  = acc_clr_q;
  assign Wb       = wb_q;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Bench for nn_layer_sequencer: per-cycle trace against a schedule model built from
// the layer rules; NN_CYCLE_COUNT_EN selects the PIPE_LAT=1 build with the counter.
module tb_nn_layer_sequencer;

`ifdef NN_CYCLE_COUNT_EN
  localparam int PL = 1;
`else
  localparam int PL = 2;
`endif
  localparam int MAXP = 1400;
  localparam int BASE = 784 + 20 + 20 + 3 * (PL + 3);

  logic       clk, rst_n, compute, hold;
  logic       busy, done, bias_sel, acc_clr, wb;
  logic [2:0] layer, acc_en;
  logic [9:0] rd_addr;
  logic [15:0] cycles;

  nn_layer_sequencer #(
    .PIPE_LAT(PL)
  ) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .Compute (compute),
    .Hold    (hold),
    .Busy    (busy),
    .Done    (done),
    .Layer   (layer),
    .Rd_addr (rd_addr),
    .Bias_sel(bias_sel),
    .Acc_clr (acc_clr),
    .Acc_en  (acc_en),
`ifdef NN_CYCLE_COUNT_EN
    .Cycles  (cycles),
`endif
    .Wb      (wb)
  );

`ifndef NN_CYCLE_COUNT_EN
  assign cycles = '0;
`endif

  always #5 clk = ~clk;

  int total, bad;
  // Period k = interval after the k-th rising edge; edge 0 samples Compute in IDLE.
  bit          hold_pat[MAXP];
  int          compute_low;
  logic [10:0] exp_ctl[MAXP];  // {busy, done, layer[2:0], acc_clr, acc_en[2:0], wb, bias}
  logic [9:0]  exp_rd[MAXP];
  bit          exp_rd_vld[MAXP];
  logic [10:0] obs_ctl[MAXP];
  logic [9:0]  obs_rd[MAXP];
  logic [15:0] obs_cycles;
  int          exp_done_at, exp_len;

  function automatic int fan(int l);
    return (l == 0) ? 784 : 20;
  endfunction

  task automatic build_model();
    int c = 0;
    int idx, last;
    for (int k = 0; k < MAXP; k++) begin
      exp_ctl[k] = '0;
      exp_rd[k] = '0;
      exp_rd_vld[k] = 1'b0;
    end
    for (int l = 0; l < 3; l++) begin
      exp_ctl[c][10] = 1'b1;
      exp_ctl[c][8:6] = 3'(1 << l);
      exp_ctl[c][5] = 1'b1;
      c++;
      idx = 0;
      while (idx <= fan(l)) begin
        exp_ctl[c][10] = 1'b1;
        exp_ctl[c][8:6] = 3'(1 << l);
        exp_rd[c] = 10'(idx);
        exp_rd_vld[c] = 1'b1;
        if (idx == fan(l)) exp_ctl[c][0] = 1'b1;
        if (!hold_pat[c]) begin
          exp_ctl[c+PL][2+l] = 1'b1;
          idx++;
        end
        c++;
      end
      for (int d = 0; d < PL; d++) begin
        exp_ctl[c][10] = 1'b1;
        exp_ctl[c][8:6] = 3'(1 << l);
        c++;
      end
      exp_ctl[c][10] = 1'b1;
      exp_ctl[c][8:6] = 3'(1 << l);
      exp_ctl[c][1] = 1'b1;
      c++;
    end
    exp_done_at = c;
    if (compute_low < 0) compute_low = c + 3;
    last = (compute_low > c) ? compute_low : c;
    for (int k = c; k <= last; k++) exp_ctl[k][9] = 1'b1;
    exp_len = last + 4;
  endtask

  task automatic run_trace();
    @(negedge clk);
    compute = 1'b1;
    hold = 1'b0;
    @(posedge clk);
    for (int k = 0; k < exp_len; k++) begin
      #1;
      obs_ctl[k] = {busy, done, layer, acc_clr, acc_en, wb, bias_sel};
      obs_rd[k] = rd_addr;
      hold = hold_pat[k];
      compute = (k < compute_low);
      @(posedge clk);
    end
    #1;
    obs_cycles = cycles;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    compute = 1'b0;
    hold = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({busy, done, layer, acc_clr, acc_en, wb, bias_sel, rd_addr} !== '0) begin
      bad++;
      $display("FAIL reset_idle got busy=%b done=%b layer=%b rd=%0d want all 0",
               busy, done, layer, rd_addr);
    end
    compute = 1'b1;
    @(posedge clk);  // edge 0
    repeat (50) @(posedge clk);
    #1;
    total++;
    if (rd_addr !== 10'd49 || layer !== 3'b001) begin
      bad++;
      $display("FAIL pre_reset_issue got rd=%0d layer=%b want rd=49 layer=001", rd_addr, layer);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, layer, acc_clr, acc_en, wb, bias_sel, rd_addr} !== '0) begin
      bad++;
      $display("FAIL async_reset got busy=%b layer=%b acc_en=%b rd=%0d want all 0",
               busy, layer, acc_en, rd_addr);
    end
    compute = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, done, layer, acc_clr, acc_en, wb, bias_sel, rd_addr} !== '0) begin
      bad++;
      $display("FAIL post_reset_idle got busy=%b layer=%b acc_en=%b rd=%0d want all 0",
               busy, layer, acc_en, rd_addr);
    end
  endtask

  task automatic test_full_run();
    int first_done = -1;
    int n_en[3] = '{0, 0, 0};
    int n_clr = 0, n_wb = 0;
    for (int k = 0; k < MAXP; k++) hold_pat[k] = 1'b0;
    compute_low = -1;
    build_model();
    run_trace();
    for (int k = 0; k < exp_len; k++) begin
      total++;
      if (obs_ctl[k] !== exp_ctl[k]) begin
        bad++;
        $display("FAIL full_ctl[%0d] got %b want %b", k, obs_ctl[k], exp_ctl[k]);
      end
      if (exp_rd_vld[k]) begin
        total++;
        if (obs_rd[k] !== exp_rd[k]) begin
          bad++;
          $display("FAIL full_rd[%0d] got %0d want %0d", k, obs_rd[k], exp_rd[k]);
        end
      end
      if (obs_ctl[k][9] && first_done < 0) first_done = k;
      for (int b = 0; b < 3; b++) n_en[b] += int'(obs_ctl[k][2+b]);
      n_clr += int'(obs_ctl[k][5]);
      n_wb += int'(obs_ctl[k][1]);
    end
    total++;
    if (first_done != BASE) begin
      bad++;
      $display("FAIL full_done_period got %0d want %0d", first_done, BASE);
    end
    total++;
    if (n_en[0] != 785 || n_en[1] != 21 || n_en[2] != 21) begin
      bad++;
      $display("FAIL full_acc_en_counts got %0d/%0d/%0d want 785/21/21", n_en[0], n_en[1], n_en[2]);
    end
    total++;
    if (n_clr != 3 || n_wb != 3) begin
      bad++;
      $display("FAIL full_clr_wb_counts got clr=%0d wb=%0d want 3/3", n_clr, n_wb);
    end
`ifdef NN_CYCLE_COUNT_EN
    total++;
    if (obs_cycles !== 16'(BASE)) begin
      bad++;
      $display("FAIL full_cycles got %0d want %0d", obs_cycles, BASE);
    end
`endif
  endtask

  task automatic test_hold();
    int l1 = 784 + PL + 3;
    int first_done = -1;
    int n_en[3] = '{0, 0, 0};
    for (int k = 0; k < MAXP; k++) hold_pat[k] = 1'b0;
    hold_pat[l1+6] = 1'b1;
    hold_pat[l1+7] = 1'b1;
    hold_pat[l1+11] = 1'b1;
    hold_pat[l1+16] = 1'b1;
    hold_pat[l1+17] = 1'b1;
    hold_pat[l1-2] = 1'b1;         // layer-1 drain
    hold_pat[l1+27] = 1'b1;        // layer-2 drain
    hold_pat[BASE+5-2] = 1'b1;     // layer-3 drain
    compute_low = -1;
    build_model();
    run_trace();
    for (int k = 0; k < exp_len; k++) begin
      total++;
      if (obs_ctl[k] !== exp_ctl[k]) begin
        bad++;
        $display("FAIL hold_ctl[%0d] got %b want %b", k, obs_ctl[k], exp_ctl[k]);
      end
      if (exp_rd_vld[k]) begin
        total++;
        if (obs_rd[k] !== exp_rd[k]) begin
          bad++;
          $display("FAIL hold_rd[%0d] got %0d want %0d", k, obs_rd[k], exp_rd[k]);
        end
      end
      if (obs_ctl[k][9] && first_done < 0) first_done = k;
      for (int b = 0; b < 3; b++) n_en[b] += int'(obs_ctl[k][2+b]);
    end
    total++;
    if (first_done != BASE + 5) begin
      bad++;
      $display("FAIL hold_done_period got %0d want %0d", first_done, BASE + 5);
    end
    total++;
    if (n_en[0] != 785 || n_en[1] != 21 || n_en[2] != 21) begin
      bad++;
      $display("FAIL hold_acc_en_counts got %0d/%0d/%0d want 785/21/21", n_en[0], n_en[1], n_en[2]);
    end
  endtask

  task automatic test_random_hold();
    int first_done = -1;
    for (int k = 0; k < MAXP; k++) hold_pat[k] = ($urandom_range(0, 4) == 0);
    compute_low = -1;
    build_model();
    run_trace();
    for (int k = 0; k < exp_len; k++) begin
      total++;
      if (obs_ctl[k] !== exp_ctl[k]) begin
        bad++;
        $display("FAIL rand_ctl[%0d] got %b want %b", k, obs_ctl[k], exp_ctl[k]);
      end
      if (exp_rd_vld[k]) begin
        total++;
        if (obs_rd[k] !== exp_rd[k]) begin
          bad++;
          $display("FAIL rand_rd[%0d] got %0d want %0d", k, obs_rd[k], exp_rd[k]);
        end
      end
      if (obs_ctl[k][9] && first_done < 0) first_done = k;
    end
    total++;
    if (first_done != exp_done_at) begin
      bad++;
      $display("FAIL rand_done_period got %0d want %0d", first_done, exp_done_at);
    end
`ifdef NN_CYCLE_COUNT_EN
    total++;
    if (obs_cycles !== 16'(exp_done_at)) begin
      bad++;
      $display("FAIL rand_cycles got %0d want %0d", obs_cycles, exp_done_at);
    end
`endif
  endtask

  task automatic test_compute_drop();
    int n_done = 0;
    for (int k = 0; k < MAXP; k++) hold_pat[k] = 1'b0;
    compute_low = 100;
    build_model();
    run_trace();
    for (int k = 0; k < exp_len; k++) begin
      total++;
      if (obs_ctl[k] !== exp_ctl[k]) begin
        bad++;
        $display("FAIL drop_ctl[%0d] got %b want %b", k, obs_ctl[k], exp_ctl[k]);
      end
      n_done += int'(obs_ctl[k][9]);
    end
    total++;
    if (n_done != 1) begin
      bad++;
      $display("FAIL drop_done_width got %0d cycles want 1", n_done);
    end
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    compute = 1'b0;
    hold = 1'b0;
    total = 0;
    bad = 0;
    test_reset();
    test_full_run();
    test_hold();
    test_random_hold();
    test_compute_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
